// File: rtl/issue_queue_pkg.sv
// Shared micro-op field layout and operand wakeup helpers for the 6502 OoO
// issue queues; functional-unit queues reuse these definitions.
package issue_queue_pkg;

    localparam int unsigned UOP_W      = 47;
    localparam int unsigned NUM_SRC    = 4;
    localparam int unsigned TAG_W      = 4;
    localparam int unsigned TAG_LSB    = 13;
    localparam int unsigned TAG_STRIDE = 5;
    localparam int unsigned RDY_LSB    = 9;
    localparam int unsigned NUM_FLAGS  = 30;
    localparam int unsigned TAG_OFFSET = 2;
    localparam int unsigned FLAG_IDX_W = $clog2(NUM_FLAGS);

    typedef logic [UOP_W-1:0]     uop_t;
    typedef logic [NUM_FLAGS-1:0] flags_t;
    typedef logic [TAG_W-1:0]     tag_t;

    // OR each source ready bit with the completion flag its tag points at;
    // tags outside the flag window never wake.
    function automatic uop_t wakeup_merge(input uop_t uop, input flags_t flags);
        uop_t                  merged;
        tag_t                  tag;
        int unsigned           tag_val;
        int unsigned           idx;
        logic [FLAG_IDX_W-1:0] fidx;
        merged = uop;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            tag     = uop[TAG_LSB + i*TAG_STRIDE +: TAG_W];
            tag_val = 32'(tag);
            idx     = tag_val - TAG_OFFSET;
            fidx    = FLAG_IDX_W'(idx);
            if ((tag_val >= TAG_OFFSET) && (idx < NUM_FLAGS)) begin
                merged[RDY_LSB + i] = uop[RDY_LSB + i] | flags[fidx];
            end
        end
        return merged;
    endfunction

    function automatic logic all_ready(input uop_t uop);
        return &uop[RDY_LSB +: NUM_SRC];
    endfunction

endpackage

// File: rtl/issue_slot.sv
// One issue-queue entry: valid bit plus micro-op register with sticky wakeup.
// Load priority: clear, dispatch write, shift from the next-younger slot.
module issue_slot
    import issue_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [NUM_FLAGS-1:0] done_flags,
    input  logic                 write_en,
    input  logic [UOP_W-1:0]     write_data,
    input  logic                 shift_en,
    input  logic                 shift_valid,
    input  logic [UOP_W-1:0]     shift_data,
    output logic                 valid,
    output logic [UOP_W-1:0]     merged,
    output logic                 issuable
);

    logic [UOP_W-1:0] data;

    always_comb begin
        merged   = wakeup_merge(data, done_flags);
        issuable = valid & all_ready(merged);
    end

    // write_data and shift_data arrive already merged with this cycle's flags
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (write_en) begin
            valid <= 1'b1;
            data  <= write_data;
        end else if (shift_en) begin
            valid <= shift_valid;
            data  <= shift_valid ? shift_data : '0;
        end else if (valid) begin
            data  <= merged;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered collapsing issue queue feeding one functional-unit port.
// Optional same-cycle dispatch bypass: define ISSUE_QUEUE_BYPASS_EN.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned INST_WIDTH = UOP_W,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_FLAGS-1:0]         done_flags,
    input  logic [INST_WIDTH-1:0]        instr_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [INST_WIDTH-1:0]        instr_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SEL_W = $clog2(DEPTH);

    logic [DEPTH-1:0]      slot_valid;
    logic [DEPTH-1:0]      slot_issuable;
    logic [DEPTH-1:0]      write_en;
    logic [DEPTH-1:0]      shift_en;
    logic [DEPTH-1:0]      shin_valid;
    logic [INST_WIDTH-1:0] slot_merged [DEPTH];
    logic [INST_WIDTH-1:0] shin_data   [DEPTH];

    logic [INST_WIDTH-1:0] in_merged;
    logic [SEL_W-1:0]      sel;
    logic                  any_issuable;
    logic                  bypass;
    logic                  in_room;
    logic                  issue_fire;
    logic                  bypass_fire;
    logic                  enq_fire;
    logic [CNT_W-1:0]      wr_idx;
    logic [CNT_W-1:0]      count_nxt;

    assign in_merged = wakeup_merge(instr_in, done_flags);

    // Oldest issuable entry wins; scanning down leaves the lowest index
    always_comb begin
        sel          = '0;
        any_issuable = 1'b0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (slot_issuable[j]) begin
                sel          = SEL_W'(j);
                any_issuable = 1'b1;
            end
        end
    end

`ifdef ISSUE_QUEUE_BYPASS_EN
    assign bypass = in_valid & ~any_issuable & all_ready(in_merged);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        in_room     = count < CNT_W'(DEPTH);
        out_valid   = ~flush & (any_issuable | bypass);
        instr_out   = '0;
        if (out_valid) begin
            instr_out = any_issuable ? slot_merged[sel] : in_merged;
        end
        issue_fire  = any_issuable & out_ready & ~flush;
        bypass_fire = bypass & out_ready & ~flush;
        in_ready    = ~flush & (in_room | (out_valid & out_ready));
        enq_fire    = in_valid & in_ready & ~bypass_fire;
        wr_idx      = issue_fire ? (count - CNT_W'(1)) : count;
        count_nxt   = count + CNT_W'(enq_fire) - CNT_W'(issue_fire);
    end

    // Issued slot and everything younger move down one position
    always_comb begin
        write_en = '0;
        shift_en = '0;
        for (int j = 0; j < DEPTH; j++) begin
            write_en[j] = enq_fire & (wr_idx == CNT_W'(j));
            shift_en[j] = issue_fire & (SEL_W'(j) >= sel);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == DEPTH - 1) begin : g_tail
            assign shin_valid[g] = 1'b0;
            assign shin_data[g]  = '0;
        end else begin : g_body
            assign shin_valid[g] = slot_valid[g+1];
            assign shin_data[g]  = slot_merged[g+1];
        end

        issue_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .clear       (flush),
            .done_flags  (done_flags),
            .write_en    (write_en[g]),
            .write_data  (in_merged),
            .shift_en    (shift_en[g]),
            .shift_valid (shin_valid[g]),
            .shift_data  (shin_data[g]),
            .valid       (slot_valid[g]),
            .merged      (slot_merged[g]),
            .issuable    (slot_issuable[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Multi-entry, age-ordered issue queue for the out-of-order 6502 core.
- Holds up to DEPTH decoded micro-ops waiting on source operands.
- Wakes operands from the completion flag vector and issues the oldest fully ready entry over a valid/ready handshake.
- Sits between rename/dispatch and a single functional-unit port; one instance per port.

Parameters:
- INST_WIDTH, 47: micro-op width.
- DEPTH, 4: number of entries (>=2).
- NUM_SRC, 4: source operand fields per micro-op.
- TAG_W, 4: bits per source tag.
- TAG_LSB, 13: bit position of source 0 tag.
- TAG_STRIDE, 5: bit spacing between consecutive tag fields.
- RDY_LSB, 9: bit position of source 0 ready bit; source i ready bit is at RDY_LSB+i.
- NUM_FLAGS, 30: width of done_flags.
- TAG_OFFSET, 2: tag t maps to done_flags[t-TAG_OFFSET].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous discard of all entries.
- done_flags  in  NUM_FLAGS  per-tag completion flags for the current cycle.
- instr_in  in  INST_WIDTH  dispatched micro-op.
- in_valid  in  1  instr_in valid.
- in_ready  out  1  queue accepts this cycle.
- instr_out  out  INST_WIDTH  selected micro-op with wakeup merged.
- out_valid  out  1  instr_out issuable.
- out_ready  in  1  functional unit accepts.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset or flush sets all entries empty. After the edge: count=0, out_valid=0, in_ready=1, instr_out=0. Reset wins over all inputs. Flush wins over enqueue and issue in the same cycle; no handshake completes that cycle.
- Wakeup is combinational per entry. Ready bit i is ORed with done_flags[tag_i-TAG_OFFSET]. The merged value is both the issue candidate this cycle and the value stored at the edge, so ready bits are sticky.
- A tag with tag < TAG_OFFSET, or with index >= NUM_FLAGS, never wakes. Its ready bit must already be set at dispatch.
- An entry is issuable when all NUM_SRC merged ready bits are 1.
- Selection: the oldest issuable entry (lowest slot index) drives instr_out. out_valid=1 iff any entry is issuable. When out_valid=0, instr_out=0.
- Issue handshake: on out_valid & out_ready, the selected entry is removed at the edge. Younger entries shift down one slot, so age order is preserved (collapsing queue).
- Enqueue handshake: in_ready = (count<DEPTH) | (out_valid & out_ready).
- On in_valid & in_ready, the micro-op is written with ready bits already merged against this cycle's done_flags. It lands at slot count, or slot count-1 if an issue happens in the same cycle.
- Simultaneous enqueue and issue leaves count unchanged. This includes the full case.
- A new entry is never issuable in its arrival cycle, except under the optional feature.
- Latency: a dispatched ready micro-op is visible on out_valid the cycle after acceptance. A done flag in cycle N can issue a waiting entry in cycle N.
- Non-ready entries never block older or younger ready entries.

Optional Feature:
- Macro: ISSUE_QUEUE_BYPASS_EN.
- Defined: when no stored entry is issuable and instr_in's merged ready bits are all 1, instr_in is presented on instr_out/out_valid in the same cycle.
  - If out_ready=1, the micro-op is not stored and count is unchanged.
  - If out_ready=0, the micro-op is enqueued normally, provided in_ready=1.
  - Combinational in_valid-to-out_valid path exists.
- Undefined: no bypass; minimum dispatch-to-issue latency is 1 cycle.

Decomposition:
- Shared package/header: field-position constants (TAG_LSB, TAG_STRIDE, RDY_LSB, TAG_W, TAG_OFFSET, NUM_FLAGS) and a wakeup-merge function. Later functional-unit queues reuse these.
- Sub-module issue_slot: one entry holding a valid bit and a data register, with wakeup-merge logic. It takes a shift-in port from the next slot, a write port from dispatch, and outputs merged data plus an issuable flag. The top module holds the priority select, shift control and count.

Test Plan:
1. Reset, then enqueue 4 micro-ops with all ready bits 1 and out_ready=0. Expect count=4, in_ready=0. Raise out_ready: entries issue in dispatch order, one per cycle; count reaches 0 after 4 cycles.
2. Enqueue A with src0 tag=5 not ready, then B fully ready. Expect B issues first while A waits. Pulse done_flags[3]: A issues that same cycle.
3. Full queue, out_valid=1, out_ready=1, in_valid=1. Expect both handshakes complete, count stays 4, and the new entry lands in slot 3.
4. Entry with tag=1 (< TAG_OFFSET) and ready bit 0, with done_flags all 1s. Expect it never issues.
5. Three entries present, assert flush together with in_valid. Expect count=0 and out_valid=0 next cycle, and the incoming micro-op dropped.
6. With ISSUE_QUEUE_BYPASS_EN, empty queue, fully ready instr_in, out_ready=1. Expect out_valid=1 in the same cycle with instr_out=instr_in, and count remains 0.
